// File: rtl/buf1_sel_arbiter.sv
// Arbitrates requesters A (full byte) and M (single-bit extract) onto the shared buf1
// select-mux and registers the result onto a one-deep valid/ready output stage.
module buf1_sel_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BIT_IDX   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             m_valid_i,
  input  logic [WIDTH-1:0] m_data_i,
  output logic             m_ready_o,
  output logic             sel_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_src_o,
  input  logic             out_ready_i,
  output logic             state_o,
  output logic [3:0]       burst_cnt_o
);

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both 1.
  // Producers hold valid and data stable until that edge; ready never waits on valid
  // of the other side, and a_ready/m_ready are mutually exclusive.

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             sel_q, sel_d;
  logic [3:0]       burst_q, burst_d;

  logic             can_load;
  logic             burst_hit;
  logic             grant_a, grant_m, grant_any;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_out;

  always_comb begin
    can_load  = (state_q == ST_EMPTY) | out_ready_i;
    burst_hit = (burst_q == MAX_CNT);
    grant_a   = can_load & a_valid_i & (~m_valid_i | ~burst_hit);
    grant_m   = can_load & m_valid_i & (~a_valid_i | burst_hit);
    grant_any = grant_a | grant_m;

    // The buf1 mux sees one operand; sel picks the whole word or the extracted bit.
    sel_d   = grant_any ? grant_a : sel_q;
    mux_a   = grant_a ? a_data_i : m_data_i;
    mux_out = sel_d ? mux_a : {{(WIDTH-1){1'b0}}, mux_a[BIT_IDX]};

    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    burst_d    = burst_q;

    case (state_q)
      ST_EMPTY: if (grant_any) state_d = ST_FULL;
      ST_FULL:  if (out_ready_i && !grant_any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (grant_any) begin
      out_data_d = mux_out;
      out_src_d  = grant_a;
    end

    if (!m_valid_i || grant_m) begin
      burst_d = 4'd0;
    end else if (grant_a && !burst_hit) begin
      burst_d = burst_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_src_q  <= 1'b0;
      sel_q      <= 1'b0;
      burst_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      sel_q      <= sel_d;
      burst_q    <= burst_d;
    end
  end

  assign a_ready_o   = grant_a;
  assign m_ready_o   = grant_m;
  assign sel_o       = sel_d;
  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign state_o     = state_q;
  assign burst_cnt_o = burst_q;

endmodule

// File: tb/tb_buf1_sel_arbiter.sv
// Directed and randomised checks of buf1_sel_arbiter: reset, single-source paths,
// A/M fairness, backpressure and a scoreboarded stress run.
module tb_buf1_sel_arbiter;

  localparam int W         = 8;
  localparam int BIT_IDX   = 2;
  localparam int MAX_BURST = 4;
  localparam int N_RAND    = 3000;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic         sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready;
  logic         state;
  logic [3:0]   burst_cnt;

  int checks = 0;
  int errors = 0;

  logic ar_s, mr_s, sel_s;
  logic [W:0] exp_q[$];

  buf1_sel_arbiter #(.WIDTH(W), .BIT_IDX(BIT_IDX), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
    .m_valid_i(m_valid), .m_data_i(m_data), .m_ready_o(m_ready),
    .sel_o(sel), .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src),
    .out_ready_i(out_ready), .state_o(state), .burst_cnt_o(burst_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Sample combinational outputs on the falling edge, registered ones just after rising.
  task automatic cycle();
    @(negedge clk);
    ar_s  = a_ready;
    mr_s  = m_ready;
    sel_s = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; m_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; m_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_src, sel, state, burst_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_init: got v=%b d=%h src=%b sel=%b st=%b bc=%0d want all zero",
               out_valid, out_data, out_src, sel, state, burst_cnt);
    end
    // Load a result and hold it, then reset mid-transfer.
    a_valid = 1'b1; a_data = 8'hE7;
    cycle();
    a_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE7) begin
      errors++;
      $display("FAIL reset_preload: got v=%b d=%h want v=1 d=e7", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h sel=%b src=%b want 0 00 0 0",
               out_valid, out_data, sel, out_src);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge: got v=%b d=%h sel=%b want 0 00 0", out_valid, out_data, sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_m();
    out_ready = 1'b1;
    m_valid = 1'b1; m_data = 8'hA4;
    cycle();
    checks++;
    if (mr_s !== 1'b1 || ar_s !== 1'b0 || sel_s !== 1'b0) begin
      errors++;
      $display("FAIL m_grant: got m_ready=%b a_ready=%b sel=%b want 1 0 0", mr_s, ar_s, sel_s);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL m_data_a4: got v=%b d=%h src=%b want 1 01 0", out_valid, out_data, out_src);
    end
    m_data = 8'hFB;
    cycle();
    checks++;
    if (mr_s !== 1'b1 || out_data !== 8'h00 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL m_data_fb: got m_ready=%b d=%h src=%b want 1 00 0", mr_s, out_data, out_src);
    end
    m_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL m_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single_a();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h5C;
    cycle();
    checks++;
    if (ar_s !== 1'b1 || mr_s !== 1'b0 || sel_s !== 1'b1) begin
      errors++;
      $display("FAIL a_grant: got a_ready=%b m_ready=%b sel=%b want 1 0 1", ar_s, mr_s, sel_s);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C || out_src !== 1'b1) begin
      errors++;
      $display("FAIL a_data_5c: got v=%b d=%h src=%b want 1 5c 1", out_valid, out_data, out_src);
    end
    a_valid = 1'b0;
    cycle();
    checks++;
    if (sel_s !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL a_idle_hold: got sel=%b v=%b want sel=1 v=0", sel_s, out_valid);
    end
  endtask

  task automatic test_fairness();
    logic exp_a;
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h33;
    m_valid = 1'b1; m_data = 8'h04;
    for (int i = 0; i < 10; i++) begin
      exp_a = ((i % 5) != 4);
      cycle();
      checks++;
      if (ar_s !== exp_a || mr_s !== !exp_a || sel_s !== exp_a) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got a_ready=%b m_ready=%b sel=%b want a=%b",
                 i, ar_s, mr_s, sel_s, exp_a);
      end
      checks++;
      if (out_src !== exp_a || out_data !== (exp_a ? 8'h33 : 8'h01)) begin
        errors++;
        $display("FAIL fair_result[%0d]: got src=%b d=%h want src=%b d=%h",
                 i, out_src, out_data, exp_a, exp_a ? 8'h33 : 8'h01);
      end
    end
    a_valid = 1'b0; m_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic exp_a;
    a_valid = 1'b1; a_data = 8'hC3;
    m_valid = 1'b1; m_data = 8'h04;
    out_ready = 1'b0;
    cycle();
    checks++;
    if (ar_s !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
      errors++;
      $display("FAIL bp_fill: got a_ready=%b v=%b d=%h want 1 1 c3", ar_s, out_valid, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (ar_s !== 1'b0 || mr_s !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hC3
          || out_src !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got a_ready=%b m_ready=%b v=%b d=%h src=%b want 0 0 1 c3 1",
                 i, ar_s, mr_s, out_valid, out_data, out_src);
      end
    end
    // One A grant already counted, so three more A then M.
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_a = (j < 3);
      cycle();
      checks++;
      if (ar_s !== exp_a || mr_s !== !exp_a || out_valid !== 1'b1 || out_src !== exp_a) begin
        errors++;
        $display("FAIL bp_release[%0d]: got a_ready=%b m_ready=%b v=%b src=%b want a=%b v=1",
                 j, ar_s, mr_s, out_valid, out_src, exp_a);
      end
    end
    a_valid = 1'b0; m_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic       a_hs, m_hs;
    logic [W:0] got, exp;
    int         m_wait;
    a_hs = 1'b0; m_hs = 1'b0; m_wait = 0;
    a_valid = 1'b0; m_valid = 1'b0;
    for (int cyc = 0; cyc < N_RAND + 20; cyc++) begin
      if (!a_valid || a_hs) begin
        a_valid = (cyc < N_RAND) ? ($urandom_range(0, 99) < 60) : 1'b0;
        a_data  = W'($urandom_range(0, 255));
      end
      if (!m_valid || m_hs) begin
        m_valid = (cyc < N_RAND) ? ($urandom_range(0, 99) < 50) : 1'b0;
        m_data  = W'($urandom_range(0, 255));
      end
      out_ready = (cyc < N_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      a_hs = a_valid & a_ready;
      m_hs = m_valid & m_ready;
      checks++;
      if (a_ready && m_ready) begin
        errors++;
        $display("FAIL rand_excl[%0d]: got a_ready=1 m_ready=1 want at most one", cyc);
      end
      if (out_valid && out_ready) begin
        got = {out_src, out_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra[%0d]: got %h with nothing expected", cyc, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rand_data[%0d]: got src/data %h want %h", cyc, got, exp);
          end
        end
      end
      if (a_hs) exp_q.push_back({1'b1, a_data});
      if (m_hs) exp_q.push_back({1'b0, {(W-1){1'b0}}, m_data[BIT_IDX]});
      if (m_hs) begin
        m_wait = 0;
      end else if (m_valid && a_hs) begin
        m_wait++;
        checks++;
        if (m_wait > MAX_BURST) begin
          errors++;
          $display("FAIL rand_starve[%0d]: got %0d A grants while M waits want <= %0d",
                   cyc, m_wait, MAX_BURST);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || a_valid || m_valid) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending v=%b av=%b mv=%b want 0 0 0 0",
               exp_q.size(), out_valid, a_valid, m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_m();
    test_single_a();
    test_fairness();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
